// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate test sequencer: FSM state encoding,
// vector count, common truth tables and the settle-counter width helper.
package gate_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int NUM_VEC = 4;

  // Expected Y indexed by {A,B}.
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;

  // Counter must hold SETTLE_CYCLES-1; keep at least one bit so a zero
  // settle time still yields a legal (unused) counter.
  function automatic int cnt_width(input int settle_cycles);
    if (settle_cycles < 1) return 1;
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_counter.sv
// Loadable down-counter timing the SETTLE phase; zero marks the last
// settle cycle.
module settle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives {A,B}=00,01,10,11 into a 2-input gate, samples Y after a settle time
// and counts mismatches against TRUTH_TABLE. Optional GATE_SEQ_ERRLOG_EN adds
// first_fail_vec / first_fail_vld.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH_TABLE   = TT_AND,
  parameter int                 SETTLE_CYCLES = 2,
  parameter int                 ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_SEQ_ERRLOG_EN
  ,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_vld
`endif
);

  // start is a level request taken only in IDLE; done is a one-cycle
  // completion pulse, and err_cnt/pass are stable from done until next start.

  localparam int               CNT_W       = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [1:0]       LAST_VEC    = 2'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state_q, state_d;
  logic [1:0]       vec_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_upd;
  logic             pass_q;
  logic             a_q, b_q;
  logic             run_start;
  logic             mismatch;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  settle_counter #(
    .W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      SETTLE:  if (cnt_zero) state_d = CHECK;
      CHECK:   state_d = (vec_q == LAST_VEC) ? FINISH : DRIVE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      DRIVE: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
      end
      SETTLE: begin
        busy    = 1'b1;
        cnt_dec = 1'b1;
      end
      CHECK:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign run_start = (state_q == IDLE) && start;
  assign mismatch  = (state_q == CHECK) && (y_i != TRUTH_TABLE[vec_q]);
  assign err_upd   = (mismatch && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;

  // The gate inputs advance on the CHECK edge so the next DRIVE cycle
  // already presents the new vector; after the last CHECK they keep 11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
    end else if (run_start) begin
      vec_q  <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
    end else if (state_q == CHECK) begin
      err_q <= err_upd;
      if (vec_q != LAST_VEC) begin
        vec_q      <= vec_q + 2'd1;
        {a_q, b_q} <= vec_q + 2'd1;
      end else begin
        pass_q <= (err_upd == '0);
      end
    end
  end

`ifdef GATE_SEQ_ERRLOG_EN
  logic [1:0] ff_vec_q;
  logic       ff_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else if (run_start) begin
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else if (mismatch && !ff_vld_q) begin
      ff_vec_q <= vec_q;
      ff_vld_q <= 1'b1;
    end
  end

  assign first_fail_vec = ff_vec_q;
  assign first_fail_vld = ff_vld_q;
`endif

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Self-checking stimulus controller for a 2-input combinational gate under test (GUT), such as the lab's `and_gate`. On `start` it drives all four input vectors onto the gate in order {A,B} = 00, 01, 10, 11. It waits a programmable settle time for each vector, samples the gate output and compares it against a parameterised truth table. It reports a mismatch count and a pass flag, which replaces manual `$monitor` inspection on the lab boards and in simulation.

## Interface
Parameters:
- `TRUTH_TABLE`, default 4'b1000, expected Y; bit index = {A,B} (default = AND).
- `SETTLE_CYCLES`, default 2, wait cycles between driving a vector and sampling Y; 0 is legal.
- `ERR_W`, default 3, width of the error counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE.
- `y_i`  in  1  GUT output.
- `a_o`  out  1  GUT input A (registered).
- `b_o`  out  1  GUT input B (registered).
- `busy`  out  1  high from first DRIVE through last CHECK.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the last run had zero mismatches; held until the next start.
- `err_cnt`  out  ERR_W  mismatches in the last run; saturates at all-ones.

## Operation
- FSM states are IDLE, DRIVE, SETTLE, CHECK and FINISH. A 2-bit vector index `vec` and a settle counter support the FSM.
- IDLE:
  - `start`=1 → DRIVE.
  - On entry to the run: `vec`=0, `err_cnt`=0, `pass`=0.
- DRIVE: `a_o`=`vec[1]`, `b_o`=`vec[0]`.
  - → SETTLE if `SETTLE_CYCLES`>0.
  - Otherwise → CHECK.
- SETTLE: stays for exactly `SETTLE_CYCLES` cycles, then → CHECK.
- CHECK: samples `y_i` and compares it with `TRUTH_TABLE[vec]`.
  - On mismatch, `err_cnt` increments, saturating.
  - If `vec`≠3: `vec`++ → DRIVE.
  - Otherwise → FINISH.
- FINISH: `done`=1 for this cycle only. `pass` = (final `err_cnt`==0), including the CHECK-cycle update. → IDLE.
- `a_o`/`b_o` stay stable from DRIVE through CHECK of each vector. After FINISH they hold vector 11 until the next run.
- `start` is ignored outside IDLE. If `start` is still high in IDLE after FINISH, a new run begins immediately.
- Reset, at any time including mid-run, forces:
  - IDLE, `vec`=0
  - `a_o`=`b_o`=0
  - `busy`=0, `done`=0, `pass`=0
  - `err_cnt`=0

  No `done` is produced for an aborted run.

## Timing
- Start sampled at edge k → DRIVE during cycle k+1. `busy` is high from k+1, and `a_o`/`b_o`=00 are valid from k+1.
- Per vector: 1 DRIVE + `SETTLE_CYCLES` SETTLE + 1 CHECK = `SETTLE_CYCLES`+2 cycles.
- `done` is asserted in cycle k+1+4·(`SETTLE_CYCLES`+2). With the defaults this is k+17.
- `busy` is low in FINISH and in IDLE.
- `y_i` is treated as combinational from `a_o`/`b_o`. It must be valid after `SETTLE_CYCLES`+1 cycles of stable inputs.
- Minimum gap between runs: 1 IDLE cycle after FINISH.

## Configuration
- `GATE_SEQ_ERRLOG_EN` defined: two extra outputs are added.
  - `first_fail_vec` (out, 2): the `vec` of the first mismatch in the run.
  - `first_fail_vld` (out, 1): set on the first mismatch.

  Both clear on start and on reset, reset value 0, and are held after FINISH. Later mismatches do not overwrite them.
- Not defined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `gate_seq_pkg`:
  - `state_t` enum (IDLE, DRIVE, SETTLE, CHECK, FINISH)
  - `NUM_VEC`=4
  - `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111 for testbench and top-level use
- One sub-module, `settle_counter`:
  - loadable down-counter with a `zero` flag
  - width `$clog2(SETTLE_CYCLES+1)`, minimum 1 bit

## Test plan
- GUT=AND, `TRUTH_TABLE`=`TT_AND`, default settle, pulse `start` → `done` at k+17, `pass`=1, `err_cnt`=0, `a_o`/`b_o` sequence 00,01,10,11 with 4 cycles each.
- GUT=OR, `TRUTH_TABLE`=`TT_AND` → `err_cnt`=2 (vectors 01, 10), `pass`=0. With the macro defined: `first_fail_vec`=01, `first_fail_vld`=1.
- GUT output stuck at 1, `ERR_W`=1, `TRUTH_TABLE`=`TT_AND` → 3 mismatches, `err_cnt` saturates at 1, `pass`=0.
- `SETTLE_CYCLES`=0 → each vector takes 2 cycles, `done` at k+9. Additionally, a `start` pulse while `busy` is ignored: a single `done` pulse, no restart.
- `rst_n` asserted during CHECK of vector 10 → all outputs 0 immediately. A new `start` then yields a full 4-vector run with the correct result.
- `start` held high → back-to-back runs, `done` every 18 cycles with default settle. `pass` holds between runs and clears at each new start.
